// File: rtl/alu_pkg.sv
// Shared definitions for the adder sequencer: op codes, FSM states, flag bundle.
// ALU_SEQ_WATCHDOG_EN adds the ABORT state used by the ISSUE watchdog.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_INC = 2'b10;
    localparam logic [1:0] OP_DEC = 2'b11;

    localparam int TIMEOUT_CYCLES = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
`ifdef ALU_SEQ_WATCHDOG_EN
        ST_DRAIN,
        ST_ABORT
`else
        ST_DRAIN
`endif
    } state_t;

    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic v;
        logic err;
    } flags_t;

    // INC/DEC drive B with all ones; the adder's cin then selects +1 or -1.
    function automatic logic op_b_is_ones(input logic [1:0] op);
        return (op == OP_INC) || (op == OP_DEC);
    endfunction

    function automatic logic op_cin(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_INC);
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status-flag generation from the effective adder operands and result.
module alu_flag_gen
    import alu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] d,
    input  logic [7:0] sum,
    input  logic       cout,
    output flags_t     flags
);

    always_comb begin
        flags.c   = cout;
        flags.z   = (sum == 8'h00);
        flags.n   = sum[7];
        // Signed overflow: operands agree in sign but the result does not.
        flags.v   = (a[7] == d[7]) && (sum[7] != a[7]);
        flags.err = 1'b0;
    end

endmodule

// File: rtl/alu_add_sequencer.sv
// en/ready initiator for the 8-bit adder: maps ADD/SUB/INC/DEC, captures result and flags.
// Optional watchdog on the ISSUE state is enabled by defining ALU_SEQ_WATCHDOG_EN.
module alu_add_sequencer
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    output logic       req_busy,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       res_c,
    output logic       res_z,
    output logic       res_n,
    output logic       res_v,
    output logic       res_err,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    output logic       add_cin,
    output logic       add_en,
    input  logic [7:0] add_out,
    input  logic       add_cout,
    input  logic       add_ready
);

    state_t     state;
    state_t     state_nxt;
    logic       ready_q;
    logic       ready_rise;
    logic       load_req;
    logic       load_res;
    flags_t     flags_new;
    flags_t     flags_q;
    logic [7:0] data_q;

`ifdef ALU_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_expire;
    logic            load_abort;

    assign wd_expire = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`endif

    // Only a fresh low-to-high ready counts, so a stale ready left over
    // from an interrupted transaction is never taken as completion.
    assign ready_rise = add_ready && !ready_q;

    alu_flag_gen u_flag_gen (
        .a     (add_a),
        .d     (add_b ^ {8{add_cin}}),
        .sum   (add_out),
        .cout  (add_cout),
        .flags (flags_new)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        load_req  = 1'b0;
        load_res  = 1'b0;
`ifdef ALU_SEQ_WATCHDOG_EN
        load_abort = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    load_req  = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ready_rise) begin
                    load_res  = 1'b1;
                    state_nxt = ST_CAPTURE;
                end
`ifdef ALU_SEQ_WATCHDOG_EN
                else if (wd_expire) begin
                    load_abort = 1'b1;
                    state_nxt  = ST_ABORT;
                end
`endif
            end
            ST_CAPTURE: state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (!add_ready) state_nxt = ST_IDLE;
            end
`ifdef ALU_SEQ_WATCHDOG_EN
            ST_ABORT: state_nxt = ST_DRAIN;
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Results are registered on the edge entering CAPTURE/ABORT so that
    // res_valid and res_* appear together in the cycle after ready.
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ready_q <= 1'b0;
            add_a   <= 8'h00;
            add_b   <= 8'h00;
            add_cin <= 1'b0;
            data_q  <= 8'h00;
            flags_q <= '0;
        end else begin
            state   <= state_nxt;
            ready_q <= add_ready;
            if (load_req) begin
                add_a   <= req_a;
                add_b   <= op_b_is_ones(req_op) ? 8'hFF : req_b;
                add_cin <= op_cin(req_op);
            end
            if (load_res) begin
                data_q  <= add_out;
                flags_q <= flags_new;
            end
`ifdef ALU_SEQ_WATCHDOG_EN
            if (load_abort) begin
                data_q  <= 8'h00;
                flags_q <= '{c: 1'b0, z: 1'b0, n: 1'b0, v: 1'b0, err: 1'b1};
            end
`endif
        end
    end

`ifdef ALU_SEQ_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (rst || load_req) begin
            wd_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign res_valid = (state == ST_CAPTURE) || (state == ST_ABORT);
    assign res_err   = flags_q.err;
`else
    assign res_valid = (state == ST_CAPTURE);
    assign res_err   = 1'b0;
`endif

    assign req_busy = (state != ST_IDLE);
    assign add_en   = (state == ST_ISSUE);
    assign res_data = data_q;
    assign res_c    = flags_q.c;
    assign res_z    = flags_q.z;
    assign res_n    = flags_q.n;
    assign res_v    = flags_q.v;

endmodule

// File: tb/tb_alu_add_sequencer.sv
// Self-checking bench for alu_add_sequencer with a behavioural adder model and reference arithmetic.
// Watchdog expectations follow ALU_SEQ_WATCHDOG_EN.
module tb_alu_add_sequencer;

    localparam logic [1:0] T_ADD = 2'b00;
    localparam logic [1:0] T_SUB = 2'b01;
    localparam logic [1:0] T_INC = 2'b10;
    localparam logic [1:0] T_DEC = 2'b11;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic [1:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       req_busy;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_c;
    logic       res_z;
    logic       res_n;
    logic       res_v;
    logic       res_err;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_cin;
    logic       add_en;
    logic [7:0] add_out   = 8'h00;
    logic       add_cout  = 1'b0;
    logic       add_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    // Adder model controls
    int lat         = 2;
    int hold        = 1;
    bit never_ready = 1'b0;
    int en_cnt      = 0;
    int hold_cnt    = 0;
    logic [8:0] model_sum;

    logic [1:0] cur_op;
    logic [7:0] cur_a;
    logic [7:0] cur_b;
    int         n;

    alu_add_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_busy  (req_busy),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_c     (res_c),
        .res_z     (res_z),
        .res_n     (res_n),
        .res_v     (res_v),
        .res_err   (res_err),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_en    (add_en),
        .add_out   (add_out),
        .add_cout  (add_cout),
        .add_ready (add_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder: inverts B when cin=1, raises ready lat cycles into en, holds it hold cycles after en drops.
    assign model_sum = {1'b0, add_a} + {1'b0, (add_cin ? ~add_b : add_b)} + {8'h00, add_cin};

    always @(posedge clk) begin
        if (add_en) begin
            en_cnt <= en_cnt + 1;
            if (!never_ready && (en_cnt + 1 >= lat)) begin
                add_ready <= 1'b1;
                add_out   <= model_sum[7:0];
                add_cout  <= model_sum[8];
                hold_cnt  <= hold;
            end
        end else begin
            en_cnt <= 0;
            if (add_ready) begin
                if (hold_cnt == 0) add_ready <= 1'b0;
                else               hold_cnt  <= hold_cnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic straight from the operation definitions.
    task automatic ref_calc(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                            output logic [7:0] r, output logic c, output logic z,
                            output logic nf, output logic v);
        int ua, ub, ures, sa, sb, sres;
        logic [31:0] rv;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            T_ADD:   begin ures = ua + ub; sres = sa + sb; c = (ures > 255); end
            T_SUB:   begin ures = ua - ub; sres = sa - sb; c = (ua >= ub);   end
            T_INC:   begin ures = ua + 1;  sres = sa + 1;  c = (ua == 255);  end
            default: begin ures = ua - 1;  sres = sa - 1;  c = (ua != 0);    end
        endcase
        rv = ures;
        r  = rv[7:0];
        z  = (r == 8'h00);
        nf = r[7];
        v  = (sres > 127) || (sres < -128);
    endtask

    task automatic start_req(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                             input string tag);
        int  k;
        bit  was_idle;
        cur_op    = op;
        cur_a     = a;
        cur_b     = b;
        was_idle  = !req_busy;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!add_en && k < 100);
        req_valid = 1'b0;
        check({tag, " en_rise"}, add_en, 1);
        if (was_idle) check({tag, " issue_latency"}, k, 1);
        check({tag, " busy"}, req_busy, 1);
        check({tag, " no_stale_ready"}, add_ready, 0);
        check({tag, " add_a"}, add_a, a);
        check({tag, " add_b"}, add_b, (op == T_INC || op == T_DEC) ? 8'hFF : b);
        check({tag, " add_cin"}, add_cin, (op == T_SUB || op == T_INC) ? 1'b1 : 1'b0);
    endtask

    task automatic finish_req(input string tag);
        logic [7:0] er;
        logic ec, ez, en_f, ev;
        int rdy_t, res_t;
        ref_calc(cur_op, cur_a, cur_b, er, ec, ez, en_f, ev);
        rdy_t = -1;
        res_t = -1;
        for (int i = 0; i < 300; i++) begin
            if (add_ready && rdy_t < 0) rdy_t = i;
            if (res_valid) begin
                res_t = i;
                break;
            end
            @(negedge clk);
        end
        check({tag, " res_seen"}, (res_t >= 0), 1);
        check({tag, " res_latency"}, res_t - rdy_t, 1);
        check({tag, " data"}, res_data, er);
        check({tag, " c"}, res_c, ec);
        check({tag, " z"}, res_z, ez);
        check({tag, " n"}, res_n, en_f);
        check({tag, " v"}, res_v, ev);
        check({tag, " err"}, res_err, 0);
        check({tag, " en_low"}, add_en, 0);
        @(negedge clk);
        check({tag, " pulse_one_cycle"}, res_valid, 0);
        check({tag, " data_hold"}, res_data, er);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = 8'h00;
        req_b     = 8'h00;
        repeat (3) @(negedge clk);
        check("rst busy", req_busy, 0);
        check("rst en", add_en, 0);
        check("rst res_valid", res_valid, 0);
        check("rst res_data", res_data, 0);
        check("rst flags", {res_c, res_z, res_n, res_v, res_err}, 5'b0);
        check("rst add_ops", {add_a, add_b, add_cin}, 17'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed arithmetic cases
        lat = 2; hold = 1;
        start_req(T_ADD, 8'h3C, 8'h05, "add_3c_05");
        finish_req("add_3c_05");
        check("add_3c_05 literal", res_data, 8'h41);

        start_req(T_SUB, 8'h00, 8'h01, "sub_00_01");
        finish_req("sub_00_01");
        check("sub_00_01 literal", {res_data, res_c, res_n}, {8'hFF, 1'b0, 1'b1});

        start_req(T_INC, 8'h7F, 8'h12, "inc_7f");
        finish_req("inc_7f");
        check("inc_7f literal", {res_data, res_v, res_n}, {8'h80, 1'b1, 1'b1});

        start_req(T_DEC, 8'h80, 8'h34, "dec_80");
        finish_req("dec_80");
        check("dec_80 literal", {res_data, res_v}, {8'h7F, 1'b1});

        // New request while ready is still held high in DRAIN
        lat = 2; hold = 4;
        start_req(T_SUB, 8'h10, 8'h10, "sub_10_10");
        finish_req("sub_10_10");
        check("sub_10_10 literal", {res_data, res_z, res_c}, {8'h00, 1'b1, 1'b1});
        check("drain ready_still_high", add_ready, 1);
        check("drain en_low", add_en, 0);
        start_req(T_ADD, 8'hF0, 8'h20, "after_drain");
        finish_req("after_drain");

        // Request during ISSUE must not disturb the operands
        lat = 6; hold = 0;
        start_req(T_ADD, 8'h11, 8'h22, "issue_ignore");
        req_valid = 1'b1;
        req_op    = T_SUB;
        req_a     = 8'hAA;
        req_b     = 8'h55;
        repeat (2) @(negedge clk);
        check("issue_ignore hold_ops", {add_a, add_b, add_cin}, {8'h11, 8'h22, 1'b0});
        req_valid = 1'b0;
        finish_req("issue_ignore");

        // Randomized traffic
        for (int i = 0; i < 24; i++) begin
            lat  = int'($urandom_range(1, 4));
            hold = int'($urandom_range(0, 3));
            start_req(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), "rand");
            finish_req("rand");
        end

        // Reset during ISSUE
        lat = 8; hold = 0;
        start_req(T_INC, 8'h01, 8'h00, "reset_mid");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid en", add_en, 0);
        check("reset_mid busy", req_busy, 0);
        check("reset_mid res_valid", res_valid, 0);
        check("reset_mid outputs", {res_data, res_c, res_z, res_n, res_v, res_err}, 13'h0);
        check("reset_mid add_ops", {add_a, add_b, add_cin}, 17'h0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_mid quiet", {res_valid, req_busy, add_en}, 3'b000);
        end

        // Adder that never answers
        never_ready = 1'b1;
        start_req(T_ADD, 8'h01, 8'h02, "wd");
`ifdef ALU_SEQ_WATCHDOG_EN
        n = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!add_en) break;
            n++;
        end
        check("wd issue_cycles", n, 15);
        check("wd res_valid", res_valid, 1);
        check("wd res_err", res_err, 1);
        check("wd res_fields", {res_data, res_c, res_z, res_n, res_v}, 12'h0);
        @(negedge clk);
        check("wd pulse_one_cycle", res_valid, 0);
        n = 0;
        while (req_busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("wd back_to_idle", req_busy, 0);
`else
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid) n++;
        end
        check("no_wd res_pulses", n, 0);
        check("no_wd en_held", add_en, 1);
        check("no_wd busy", req_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("no_wd reset_recover", {req_busy, add_en}, 2'b00);
`endif
        never_ready = 1'b0;
        @(negedge clk);

        lat = 1; hold = 0;
        start_req(T_DEC, 8'h00, 8'h00, "dec_00");
        finish_req("dec_00");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
